// File: rtl/lcd1602_reader_if.sv
// lcd1602_reader_if: request/result handshake and LCD bus lines of the LCD1602 reader
interface lcd1602_reader_if;
  logic       req;
  logic       rs_sel;
  logic       ready;
  logic       valid;
  logic [7:0] rd_data;
  logic       busy_flag;
  logic [6:0] addr_cnt;
  logic       poll_req;
  logic       poll_done;
  logic       poll_timeout;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_in;
  logic       bus_own;
  modport master (
    output req, rs_sel, poll_req, lcd_data_in,
    input  ready, valid, rd_data, busy_flag, addr_cnt, poll_done, poll_timeout,
           lcd_rs, lcd_rw, lcd_en, bus_own
  );
  modport slave (
    input  req, rs_sel, poll_req, lcd_data_in,
    output ready, valid, rd_data, busy_flag, addr_cnt, poll_done, poll_timeout,
           lcd_rs, lcd_rw, lcd_en, bus_own
  );
endinterface

// File: rtl/lcd1602_reader.sv
// lcd1602_reader: HD44780 8-bit read cycles (BF/address or data) on the shared LCD bus.
// Busy-flag polling engine is compiled in with LCD_BF_POLL_EN.
module lcd1602_reader #(
  parameter int SETUP_CYC    = 3,
  parameter int EN_HIGH_CYC  = 25,
  parameter int HOLD_CYC     = 3,
  parameter int POLL_GAP_CYC = 50,
  parameter int POLL_MAX     = 255
) (
  input logic             clk,
  input logic             rst,
  lcd1602_reader_if.slave bus
);
  localparam int M0 = SETUP_CYC > EN_HIGH_CYC ? SETUP_CYC : EN_HIGH_CYC;
  localparam int M1 = HOLD_CYC > POLL_GAP_CYC ? HOLD_CYC : POLL_GAP_CYC;
  localparam int CW = $clog2((M0 > M1 ? M0 : M1) + 1);
`ifdef LCD_BF_POLL_EN
  localparam int PW = $clog2(POLL_MAX + 1);
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, DONE, POLL_GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, DONE} state_t;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, len;
  logic          rs_q, rs_d, fin, act;
  logic [7:0]    samp_q, rd_q;
  logic          bf_q;
  logic [6:0]    ac_q;
`ifdef LCD_BF_POLL_EN
  logic          poll_q, poll_d, tmo;
  logic [PW-1:0] pc_q, pc_d;
  assign tmo = pc_q == PW'(POLL_MAX);
`endif
  assign fin = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    rs_d = rs_q;
`ifdef LCD_BF_POLL_EN
    poll_d = poll_q;
    pc_d = pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = SETUP;
          rs_d = bus.rs_sel;
        end
`ifdef LCD_BF_POLL_EN
        else if (bus.poll_req) begin
          state_d = SETUP;
          rs_d = 1'b0;
          poll_d = 1'b1;
          pc_d = '0;
        end
`endif
      end
      SETUP: state_d = fin ? EN_HI : SETUP;
      EN_HI: state_d = fin ? HOLD : EN_HI;
      HOLD: begin
        state_d = fin ? DONE : HOLD;
`ifdef LCD_BF_POLL_EN
        pc_d = pc_q + PW'(fin && poll_q);
`endif
      end
`ifdef LCD_BF_POLL_EN
      DONE: begin
        state_d = poll_q && bf_q && !tmo ? POLL_GAP : IDLE;
        poll_d = state_d == POLL_GAP;
      end
      POLL_GAP: state_d = fin ? SETUP : POLL_GAP;
`else
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    len = state_d == SETUP ? CW'(SETUP_CYC - 1) :
          state_d == EN_HI ? CW'(EN_HIGH_CYC - 1) :
          state_d == HOLD  ? CW'(HOLD_CYC - 1) : CW'(POLL_GAP_CYC - 1);
    cnt_d = state_d != state_q ? len : cnt_q - 1'b1;
  end
  // byte is captured while EN is still high, published on DONE entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rs_q <= 1'b0;
      samp_q <= '0;
      rd_q <= '0;
      bf_q <= 1'b1;
      ac_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rs_q <= rs_d;
      if (state_q == EN_HI && fin) samp_q <= bus.lcd_data_in;
      if (state_q == HOLD && fin) begin
        rd_q <= samp_q;
        if (!rs_q) {bf_q, ac_q} <= samp_q;
      end
    end
  end
`ifdef LCD_BF_POLL_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      poll_q <= 1'b0;
      pc_q <= '0;
    end else begin
      poll_q <= poll_d;
      pc_q <= pc_d;
    end
  end
  assign bus.poll_done    = state_q == DONE && poll_q && !bf_q;
  assign bus.poll_timeout = state_q == DONE && poll_q && bf_q && tmo;
`else
  logic unused_poll;
  assign unused_poll      = bus.poll_req | (POLL_MAX == 0);
  assign bus.poll_done    = 1'b0;
  assign bus.poll_timeout = 1'b0;
`endif
  assign act           = state_q == SETUP || state_q == EN_HI || state_q == HOLD;
  assign bus.ready     = state_q == IDLE;
  assign bus.valid     = state_q == DONE;
  assign bus.rd_data   = rd_q;
  assign bus.busy_flag = bf_q;
  assign bus.addr_cnt  = ac_q;
  assign bus.lcd_rs    = act && rs_q;
  assign bus.lcd_rw    = act;
  assign bus.lcd_en    = state_q == EN_HI;
  assign bus.bus_own   = act;
endmodule

// File: tb/tb_lcd1602_reader.sv
// tb_lcd1602_reader: vector table + scoreboard bench for lcd1602_reader (both LCD_BF_POLL_EN builds)
module tb_lcd1602_reader;
  typedef struct {
    logic       rs;
    logic [7:0] bus;
    logic       pr;
    logic [7:0] rd;
    logic       bf;
    logic [6:0] ad;
  } vec_t;
  typedef struct {
    logic [7:0] rd;
    logic       bf;
    logic [6:0] ad;
    logic       dn;
    logic       to;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] bus_val = 8'h00;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sbq[$];
  vec_t       tv[8];
  lcd1602_reader_if bif ();
  lcd1602_reader #(.POLL_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bif));
  always #5 clk = ~clk;
  // bus drives the complement while EN is low so late sampling is visible
  assign bif.lcd_data_in = bif.lcd_en ? bus_val : ~bus_val;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) begin
    if (bif.valid) begin
      if (sbq.size() == 0) chk("spurious_valid", 32'(bif.valid), 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rd_data", 32'(bif.rd_data), 32'(e.rd));
        chk("busy_flag", 32'(bif.busy_flag), 32'(e.bf));
        chk("addr_cnt", 32'(bif.addr_cnt), 32'(e.ad));
        chk("poll_done", 32'(bif.poll_done), 32'(e.dn));
        chk("poll_timeout", 32'(bif.poll_timeout), 32'(e.to));
      end
    end
  end
  task automatic check_reset_state();
    chk("rst_en", 32'(bif.lcd_en), 0);
    chk("rst_rw", 32'(bif.lcd_rw), 0);
    chk("rst_rs", 32'(bif.lcd_rs), 0);
    chk("rst_own", 32'(bif.bus_own), 0);
    chk("rst_valid", 32'(bif.valid), 0);
    chk("rst_done", 32'(bif.poll_done), 0);
    chk("rst_tmo", 32'(bif.poll_timeout), 0);
    chk("rst_rd", 32'(bif.rd_data), 0);
    chk("rst_bf", 32'(bif.busy_flag), 1);
    chk("rst_ac", 32'(bif.addr_cnt), 0);
  endtask
  task automatic do_read(input vec_t v);
    int   n;
    logic ok;
    exp_t e;
    @(negedge clk);
    chk("ready_before", 32'(bif.ready), 1);
    bus_val = v.bus;
    bif.rs_sel = v.rs;
    bif.poll_req = v.pr;
    bif.req = 1'b1;
    e = '{v.rd, v.bf, v.ad, 1'b0, 1'b0};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    bif.poll_req = 1'b0;
    n = 0;
    ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      ok = ok & (bif.lcd_en === (n >= 4 && n <= 28)) & (bif.lcd_rw === (n <= 31))
              & (bif.bus_own === (n <= 31)) & (bif.lcd_rs === (v.rs && n <= 31));
    end while (!bif.valid && n < 100);
    chk("latency", 32'(n), 32);
    chk("protocol", 32'(ok), 1);
    @(negedge clk);
    chk("ready_after", 32'(bif.ready), 1);
  endtask
`ifdef LCD_BF_POLL_EN
  task automatic poll_seq(input logic [7:0] b, input int nr, input logic to);
    int         n;
    logic [7:0] x;
    exp_t       e;
    @(negedge clk);
    bus_val = b;
    for (int r = 1; r <= nr; r++) begin
      x = (r == nr && !to) ? 8'h00 : b;
      e = '{x, x[7], x[6:0], r == nr && !to, r == nr && to};
      sbq.push_back(e);
    end
    bif.poll_req = 1'b1;
    @(posedge clk);
    #1;
    bif.poll_req = 1'b0;
    for (int r = 1; r <= nr; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 10) chk("poll_ready_low", 32'(bif.ready), 0);
      end while (!bif.valid && n < 200);
      if (r == 1) chk("poll_latency", 32'(n), 32);
      else chk("poll_gap", 32'(n), 82);
      if (r == nr - 1 && !to) bus_val = 8'h00;
    end
    @(negedge clk);
    chk("poll_idle", 32'(bif.ready), 1);
  endtask
`endif
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g;
    bif.req = 1'b0;
    bif.rs_sel = 1'b0;
    bif.poll_req = 1'b0;
    tv[0] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1, 7'h00};
    tv[1] = '{1'b0, 8'h8C, 1'b0, 8'h8C, 1'b1, 7'h0C};
    tv[2] = '{1'b1, 8'h3C, 1'b0, 8'h3C, 1'b1, 7'h0C};
    tv[3] = '{1'b0, 8'h05, 1'b0, 8'h05, 1'b0, 7'h05};
    tv[4] = '{1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0, 7'h05};
    tv[5] = '{1'b0, 8'h7F, 1'b0, 8'h7F, 1'b0, 7'h7F};
    tv[6] = '{1'b0, 8'h80, 1'b0, 8'h80, 1'b1, 7'h00};
    tv[7] = '{1'b1, 8'h42, 1'b1, 8'h42, 1'b1, 7'h00};
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_post_rst", 32'(bif.ready), 1);
    foreach (tv[i]) do_read(tv[i]);
    @(negedge clk);
    bif.rs_sel = 1'b1;
    bif.req = 1'b1;
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_mid_setup_rst", 32'(bif.ready), 1);
    @(negedge clk);
    bus_val = 8'h3A;
    bif.req = 1'b1;
    @(posedge clk);
    #1;
    bif.req = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!bif.lcd_en && g < 100);
    chk("en_rise", 32'(bif.lcd_en), 1);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("en_rst_en", 32'(bif.lcd_en), 0);
    chk("en_rst_own", 32'(bif.bus_own), 0);
    chk("en_rst_rd", 32'(bif.rd_data), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("en_rst_idle", 32'(bif.ready), 1);
`ifdef LCD_BF_POLL_EN
    poll_seq(8'h8C, 4, 1'b0);
    poll_seq(8'h80, 4, 1'b1);
`else
    @(negedge clk);
    bif.poll_req = 1'b1;
    @(posedge clk);
    #1;
    bif.poll_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("poll_ignored_ready", 32'(bif.ready), 1);
    chk("poll_ignored_own", 32'(bif.bus_own), 0);
`endif
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lcd1602_reader.md
# lcd1602_reader

Read-side companion to the LCD1602 write controller. It performs HD44780 8-bit read cycles (RW=1) on the shared LCD bus under a request/valid handshake. It returns either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1). This lets the display path wait on the busy flag instead of fixed delays. An optional busy-flag polling engine is available.

## Interface
Parameters:
- SETUP_CYC, 3: clk cycles with RS/RW stable and EN low before EN rises (tAS ≥ 60 ns at 50 MHz).
- EN_HIGH_CYC, 25: clk cycles EN held high (PWEH ≥ 450 ns).
- HOLD_CYC, 3: clk cycles with EN low, RS/RW held, after EN falls (tAH).
- POLL_GAP_CYC, 50: idle cycles between successive busy-flag reads (poll engine only).
- POLL_MAX, 255: maximum busy-flag reads before timeout (poll engine only).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  start a single read; sampled only in IDLE.
- rs_sel  in  1  0 = busy flag/address read, 1 = data read; captured with req.
- ready  out  1  high in IDLE with no poll active.
- valid  out  1  one-cycle pulse; rd_data, busy_flag and addr_cnt are updated on this cycle.
- rd_data  out  8  raw byte sampled from the bus.
- busy_flag  out  1  rd_data[7] of the last RS=0 read.
- addr_cnt  out  7  rd_data[6:0] of the last RS=0 read.
- poll_req  in  1  start busy-flag polling.
- poll_done  out  1  one-cycle pulse when BF=0 is seen.
- poll_timeout  out  1  one-cycle pulse when POLL_MAX is exhausted.
- lcd_rs, lcd_rw, lcd_en  out  1 each  LCD control lines.
- lcd_data_in  in  8  LCD D7..D0, input direction.
- bus_own  out  1  high while a read cycle is in progress; the write controller tri-states D7..D0 and releases RS/RW/EN while this is high.

## Operation
- States: IDLE, SETUP, EN_HI, HOLD, DONE, plus POLL_GAP when the poll engine is compiled in.
- IDLE: lcd_en=0, lcd_rw=0, lcd_rs=0, bus_own=0, ready=1. On req=1, latch rs_sel and go to SETUP. If req and poll_req are high together, req wins.
- SETUP: lcd_rw=1, lcd_rs=latched rs_sel, bus_own=1. Lasts SETUP_CYC cycles, then EN_HI.
- EN_HI: lcd_en=1 for EN_HIGH_CYC cycles. lcd_data_in is registered on the last EN_HI cycle, while EN is still high.
- HOLD: lcd_en=0. RS/RW stay unchanged for HOLD_CYC cycles.
- DONE: valid=1 for one cycle. rd_data takes the sampled byte. If rs_sel=0, busy_flag and addr_cnt update; otherwise they keep their old values. lcd_rw returns to 0 and bus_own to 0. Next state is IDLE, or POLL_GAP during a poll.
- req is ignored outside IDLE. There is no queueing.
- Timing counter: one down-counter, wide enough for max(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, POLL_GAP_CYC). Reloaded on every state entry.
- Reset (rst=0 at a clock edge), including mid-cycle: next state is IDLE, lcd_en=0, lcd_rw=0, lcd_rs=0, bus_own=0, valid=0, poll_done=0, poll_timeout=0, rd_data=0, busy_flag=1, addr_cnt=0, poll counter=0. ready becomes 1 on the following cycle.

## Timing
- req high at edge k in IDLE: SETUP occupies k+1..k+3, EN_HI k+4..k+28, HOLD k+29..k+31. valid is asserted in cycle k+32 (defaults).
- General latency: SETUP_CYC + EN_HIGH_CYC + HOLD_CYC + 1 cycles from the req edge to valid.
- Earliest next req is accepted at cycle k+33.
- lcd_en never rises in the same cycle that RS/RW change. RS/RW never change while lcd_en=1.

## Configuration
- LCD_BF_POLL_EN defined:
  - poll_req in IDLE starts a sequence of RS=0 reads.
  - Each DONE with busy_flag=0 pulses poll_done and returns to IDLE.
  - Each DONE with busy_flag=1 waits POLL_GAP_CYC cycles in POLL_GAP, then re-enters SETUP.
  - After POLL_MAX reads all return BF=1, poll_timeout pulses (same cycle as the final valid) and the block returns to IDLE.
  - ready stays 0 for the whole poll.
- LCD_BF_POLL_EN undefined: poll_req is ignored, poll_done and poll_timeout are tied to 0, and the POLL_GAP state and poll counter are not synthesized.

## Test plan
- Reset: hold rst=0 for 2 cycles, with a req issued mid-SETUP beforehand -> all outputs at reset values, ready=1 one cycle after release.
- Data read: rs_sel=1, bus model drives 0xA5 while EN is high -> valid at k+32, rd_data=0xA5, busy_flag=1 and addr_cnt=0 unchanged, rs high throughout.
- BF/address read: rs_sel=0, bus drives 0x8C -> busy_flag=1, addr_cnt=0x0C. EN high for exactly 25 cycles; RS/RW stable 3 cycles before EN rises and 3 cycles after it falls.
- Reset mid-EN_HI: rst=0 at EN cycle 10 -> lcd_en=0 and bus_own=0 at the next edge, no valid pulse.
- With LCD_BF_POLL_EN: bus returns BF=1 for 3 reads, then 0x00 -> 4 valid pulses, 50-cycle gaps between reads, one poll_done together with the 4th valid.
- With LCD_BF_POLL_EN, POLL_MAX=4, bus stuck at 0x80 -> 4 reads, poll_timeout pulses on the 4th valid, no poll_done, block returns to IDLE.
